// File: rtl/fetch_queue_unit_pkg.sv
// rtl/fetch_queue_unit_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_queue_unit_pkg;

    localparam int DEF_PC_W  = 9;
    localparam int DEF_INS_W = 32;
    localparam int PC_STEP   = 4;

    typedef struct packed {
        logic [DEF_PC_W-1:0]  pc;
        logic [DEF_INS_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// rtl/fetch_queue_unit_fifo.sv - DEPTH-entry prefetch FIFO with clear, count and combinational head
module fetch_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  entry_t        push_data,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: count gates every read through out_valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - PC generator, in-order imem port and prefetch queue feeding decode
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INS_W    = DEF_INS_W,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         redirect_valid,
    input  logic [PC_W-1:0]              redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [PC_W-1:0]              imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [INS_W-1:0]             imem_rsp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [INS_W-1:0]             out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         rsp_err
);

    localparam int              OW   = $clog2(MAX_OUT + 1);
    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [PC_W-1:0] target_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop;
    logic            flush;
    logic            rsp_ok;
    logic            req_fire;
    logic            push;
    logic            pop;
    entry_t          head;
    entry_t          push_data;

    assign flush     = hold || redirect_valid;
    assign target_pc = hold ? RESET_PC : redirect_pc;
    assign rsp_ok    = imem_rsp_valid && (outstanding != '0);

    // Queue slots are reserved at request time, so a response can always be pushed.
    assign imem_req_valid = !reset && !flush
                          && ((int'(count) + int'(outstanding)) < DEPTH)
                          && (int'(outstanding) < MAX_OUT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push      = rsp_ok && (drop == '0) && !flush;
    assign push_data = '{pc: rsp_pc, instr: imem_rsp_data};
    assign out_valid = (count != '0) && !hold;
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            rsp_err     <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(rsp_ok);
            if (imem_rsp_valid && (outstanding == '0)) rsp_err <= 1'b1;
            if (flush) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                // Every request still in flight after this cycle is stale.
                drop     <= outstanding - OW'(rsp_ok);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (rsp_ok) begin
                    if (drop != '0) drop   <= drop - OW'(1);
                    else            rsp_pc <= rsp_pc + STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - scoreboard bench for fetch_queue_unit with in-order memory model
module tb_fetch_queue_unit;

    localparam int         PC_W     = 9;
    localparam int         INS_W    = 32;
    localparam int         DEPTH    = 4;
    localparam int         MAX_OUT  = 2;
    localparam logic [8:0] RESET_PC = 9'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [8:0]  imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;
    logic        rsp_err;

    fetch_queue_unit #(
        .PC_W     (PC_W),
        .INS_W    (INS_W),
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hold           (hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count),
        .rsp_err        (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] ins_of(input logic [8:0] pc);
        return {16'hC0DE, 7'd0, pc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // In-order instruction memory: each accepted request answers after 1+mem_extra cycles.
    typedef struct { logic [8:0] addr; int due; } mreq_t;
    mreq_t memq[$];
    int    cyc       = 0;
    int    mem_extra = 0;
    logic  inject    = 1'b0;
    logic  nxt_reset = 1'b1;
    logic  nxt_hold  = 1'b0;
    logic  nxt_ready = 1'b1;
    logic  nxt_req_ready = 1'b1;

    task automatic step(input logic redir = 1'b0, input logic [8:0] rpc = 9'h000);
        @(posedge clk);
        #1;
        cyc++;
        reset = nxt_reset;
        if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins_of(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = inject;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        hold           = nxt_hold;
        out_ready      = nxt_ready;
        imem_req_ready = nxt_req_ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        if (reset) memq.delete();
        else if (imem_req_valid && imem_req_ready)
            memq.push_back('{imem_req_addr, cyc + 1 + mem_extra});
    endtask

    // Reference stream: after any flush point the decode side must see target, target+4, ...
    typedef struct { logic [8:0] pc; logic [31:0] instr; } exp_t;
    exp_t       expq[$];
    logic [8:0] exp_next = 9'h000;

    task automatic restart(input logic [8:0] pc);
        expq.delete();
        for (int i = 0; i < 8; i++) begin
            expq.push_back('{pc, ins_of(pc)});
            pc = pc + 9'd4;
        end
        exp_next = pc;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            restart(RESET_PC);
        end else if (hold) begin
            check("hold_out_valid", {31'd0, out_valid}, 32'd0);
            restart(RESET_PC);
        end else if (redirect_valid) begin
            restart(redirect_pc);
        end else if (out_valid && out_ready) begin
            while (expq.size() < 8) begin
                expq.push_back('{exp_next, ins_of(exp_next)});
                exp_next = exp_next + 9'd4;
            end
            e = expq.pop_front();
            check("out_pc", {23'd0, out_pc}, {23'd0, e.pc});
            check("out_instr", out_instr, e.instr);
        end
    end

    initial begin
        int lat;
        int n;
        reset = 1'b1; hold = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b1;

        repeat (3) step();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

        // First fetch: out_valid two cycles after the first non-reset cycle.
        nxt_reset = 1'b0;
        step();
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("first_valid_latency", lat, 32'd2);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_pc", {23'd0, out_pc}, 32'(4 * k));
        end

        // Decode stall fills the queue and stops requests.
        nxt_ready = 1'b0;
        repeat (10) step();
        check("stall_count", {29'd0, count}, 32'd4);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        nxt_ready = 1'b1;
        repeat (8) step();

        // Redirect with two requests in flight on slow memory.
        mem_extra = 1;
        n = 0;
        do begin
            step();
            n++;
        end while (memq.size() != 2 && n < 30);
        check("two_in_flight_found", {31'd0, memq.size() == 2}, 32'd1);
        mem_extra = 0;
        step(1'b1, 9'h040);
        step();
        check("redir_t1_out_valid", {31'd0, out_valid}, 32'd0);
        check("redir_t1_req_addr", {23'd0, imem_req_addr}, 32'h040);
        step();
        check("redir_t2_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("redir_t3_out_valid", {31'd0, out_valid}, 32'd1);
        check("redir_t3_out_pc", {23'd0, out_pc}, 32'h040);
        repeat (4) step();

        // Debug hold parks fetch at RESET_PC.
        nxt_hold = 1'b1;
        repeat (5) step();
        nxt_hold = 1'b0;
        step();
        check("hold_release_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("hold_release_req_addr", {23'd0, imem_req_addr}, {23'd0, RESET_PC});
        repeat (6) step();

        // PC wrap at the top of the address space.
        step(1'b1, 9'h1FC);
        step();
        check("wrap_req_addr0", {23'd0, imem_req_addr}, 32'h1FC);
        step();
        check("wrap_req_valid1", {31'd0, imem_req_valid}, 32'd1);
        check("wrap_req_addr1", {23'd0, imem_req_addr}, 32'h000);
        repeat (6) step();

        // Spurious response with nothing outstanding.
        nxt_ready = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(count == 3'd4 && memq.size() == 0) && n < 30);
        check("err_setup_full", {29'd0, count}, 32'd4);
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        check("rsp_err_set", {31'd0, rsp_err}, 32'd1);
        check("rsp_err_count", {29'd0, count}, 32'd4);
        repeat (3) step();
        check("rsp_err_sticky", {31'd0, rsp_err}, 32'd1);
        nxt_ready = 1'b1;
        repeat (6) step();

        // Randomized traffic against the reference stream.
        for (int i = 0; i < 400; i++) begin
            nxt_ready     = ($urandom_range(0, 9) < 7);
            nxt_req_ready = ($urandom_range(0, 9) < 8);
            mem_extra     = $urandom_range(0, 2);
            nxt_hold      = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                step(1'b1, {7'($urandom_range(0, 127)), 2'b00});
            else
                step();
            check("count_bound", {31'd0, count <= 3'd4}, 32'd1);
        end
        nxt_hold = 1'b0; nxt_ready = 1'b1; nxt_req_ready = 1'b1; mem_extra = 0;

        // Reset mid-operation drops all state, including the sticky error.
        nxt_reset = 1'b1;
        repeat (2) step();
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        nxt_reset = 1'b0;
        repeat (3) step();
        check("midrst_restart_pc", {23'd0, out_pc}, {23'd0, RESET_PC});
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
